reg_file: RTL

Integer register file for the single-cycle RISC-V core: 32 × 32-bit architectural registers, two combinational read ports and one synchronous write port. Read ports drive the ALU operand inputs (data_1 / data_2 via the operand mux); the write port takes the writeback result. After reset a sequential clear sweep zeroes the storage, so the array maps to distributed RAM rather than resettable flops. `ready_o` tells the core when the sweep is done.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/reg_file_clear_fsm.sv | 32 +++
 rtl/reg_file.sv | 42 ++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the integer register file
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
endpackage

// File: rtl/reg_file_clear_fsm.sv
// reg_file_clear_fsm: post-reset clear sweep over x1..xN and ready flag
module reg_file_clear_fsm
  import riscv_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);
  rf_state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= RF_INIT;
      ptr   <= ADDR_W'(1);
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      ready <= state_n == RF_RUN;
    end
  end
  always_comb begin
    clr_en   = state == RF_INIT;
    clr_addr = ptr;
    state_n  = clr_en && &ptr ? RF_RUN : state;
    ptr_n    = clr_en && !(&ptr) ? ptr + 1'b1 : ptr;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W integer register file with sweep clear and optional write bypass
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              ready_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              clr_en, wb_en, hit1, hit2;
  logic [ADDR_W-1:0] clr_addr;
  reg_file_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready_o)
  );
  // ready_o is high exactly in RUN, so it also gates writeback and reads
  always_comb begin
    wb_en = ready_o && reg_write_i && rd_addr_i != ADDR_W'(REG_ZERO);
    hit1  = BYPASS != 0 && wb_en && rd_addr_i == rs1_addr_i;
    hit2  = BYPASS != 0 && wb_en && rd_addr_i == rs2_addr_i;
    rs1_data_o = !ready_o || rs1_addr_i == ADDR_W'(REG_ZERO) ? '0 : hit1 ? rd_data_i : mem[rs1_addr_i];
    rs2_data_o = !ready_o || rs2_addr_i == ADDR_W'(REG_ZERO) ? '0 : hit2 ? rd_data_i : mem[rs2_addr_i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni && clr_en) mem[clr_addr] <= '0;
    else if (rst_ni && wb_en) mem[rd_addr_i] <= rd_data_i;
  end
endmodule
